// File: rtl/buff_uart_tx.sv
// rtl/buff_uart_tx.sv - streams the 256-byte ADC buffer as one UART 8N1 frame behind a two-byte sync header
// Defining BUFF_TX_CKSUM_EN appends a mod-256 sum of the data bytes as a trailing byte.
module buff_uart_tx #(
  parameter int unsigned CLK_DIV = 217,
  parameter logic [7:0]  HDR0    = 8'hA5,
  parameter logic [7:0]  HDR1    = 8'h5A
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       write_done,
  output logic [7:0] read_addr,
  input  logic [7:0] dout,
  output logic       txd,
  output logic       busy,
  output logic       frame_done,
  output logic       overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_SEND,
    S_CKSUM,
    S_DONE
  } state_t;

  localparam logic [15:0] BIT_LAST = 16'(CLK_DIV - 1);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_bit_cnt;
  logic [3:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic        r_hdr_sel;
  logic [7:0]  r_addr;
  logic        r_overrun;

  logic w_start;
  logic w_tx;
  logic w_bit_end;
  logic w_stop_start;
  logic w_stop_end;
  logic w_last_byte;
  logic w_load_data;
  logic w_data_bit_end;

  // A frame can be accepted from IDLE or from the DONE cycle, so frames may run back-to-back.
  assign w_start        = ((r_state == S_IDLE) || (r_state == S_DONE)) && write_done;
  assign w_tx           = (r_state == S_HDR) || (r_state == S_SEND) || (r_state == S_CKSUM);
  assign w_bit_end      = w_tx && (r_bit_cnt == BIT_LAST);
  assign w_stop_start   = w_bit_end && (r_bit_idx == 4'd8);
  assign w_stop_end     = w_bit_end && (r_bit_idx == 4'd9);
  assign w_data_bit_end = w_bit_end && (r_bit_idx != 4'd0) && (r_bit_idx != 4'd9);
  // Address advances during every data stop bit, so it reads 0 again only after byte 255.
  assign w_last_byte    = (r_state == S_SEND) && (r_addr == 8'd0);
  assign w_load_data    = w_stop_end &&
                          (((r_state == S_HDR) && r_hdr_sel) ||
                           ((r_state == S_SEND) && !w_last_byte));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (write_done) w_next = S_HDR;
      end
      S_HDR: begin
        if (w_stop_end && r_hdr_sel) w_next = S_SEND;
      end
      S_SEND: begin
        if (w_stop_end && w_last_byte) begin
`ifdef BUFF_TX_CKSUM_EN
          w_next = S_CKSUM;
`else
          w_next = S_DONE;
`endif
        end
      end
      S_CKSUM: begin
        if (w_stop_end) w_next = S_DONE;
      end
      S_DONE: begin
        w_next = write_done ? S_HDR : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    txd        = 1'b1;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (r_state)
      S_HDR, S_SEND, S_CKSUM: begin
        busy = 1'b1;
        if (r_bit_idx == 4'd0) begin
          txd = 1'b0;
        end else if (r_bit_idx != 4'd9) begin
          txd = r_shift[0];
        end
      end
      S_DONE: frame_done = 1'b1;
      default: begin
        txd = 1'b1;
      end
    endcase
  end

`ifdef BUFF_TX_CKSUM_EN
  logic [7:0] r_acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= 8'd0;
    end else if (w_start) begin
      r_acc <= 8'd0;
    end else if (w_load_data) begin
      r_acc <= r_acc + dout;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_cnt <= 16'd0;
      r_bit_idx <= 4'd0;
      r_shift   <= 8'd0;
      r_hdr_sel <= 1'b0;
      r_addr    <= 8'd0;
    end else if (w_start) begin
      r_bit_cnt <= 16'd0;
      r_bit_idx <= 4'd0;
      r_shift   <= HDR0;
      r_hdr_sel <= 1'b0;
      r_addr    <= 8'd0;
    end else if (w_tx) begin
      if (w_bit_end) begin
        r_bit_cnt <= 16'd0;
        r_bit_idx <= (r_bit_idx == 4'd9) ? 4'd0 : r_bit_idx + 4'd1;
      end else begin
        r_bit_cnt <= r_bit_cnt + 16'd1;
      end
      if (w_stop_start && (r_state == S_SEND)) begin
        r_addr <= r_addr + 8'd1;
      end
      if (w_data_bit_end) begin
        r_shift <= {1'b0, r_shift[7:1]};
      end else if (w_stop_end && (r_state == S_HDR) && !r_hdr_sel) begin
        r_shift   <= HDR1;
        r_hdr_sel <= 1'b1;
      end else if (w_load_data) begin
        r_shift <= dout;
      end
`ifdef BUFF_TX_CKSUM_EN
      else if (w_stop_end && w_last_byte) begin
        r_shift <= r_acc;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (write_done && busy) begin
      r_overrun <= 1'b1;
    end
  end

  assign read_addr = r_addr;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_buff_uart_tx.sv
// tb/tb_buff_uart_tx.sv - scoreboard bench for buff_uart_tx with registered-read buffer model and UART decoder
module tb_buff_uart_tx;

  localparam int DIV      = 4;
  localparam int BYTE_CYC = 10 * DIV;
`ifdef BUFF_TX_CKSUM_EN
  localparam int NBYTES = 259;
`else
  localparam int NBYTES = 258;
`endif
  localparam int FRAME_CYC = NBYTES * BYTE_CYC;

  logic       clk = 1'b0;
  logic       reset;
  logic       write_done;
  logic [7:0] read_addr;
  logic [7:0] dout;
  logic       txd;
  logic       busy;
  logic       frame_done;
  logic       overrun;

  logic [7:0] mem [256];
  logic [7:0] exp_q [$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cyc = 0;

  bit         mon_act;
  int         mon_off;
  int         mon_bi;
  logic [7:0] mon_b;

  buff_uart_tx #(.CLK_DIV(DIV), .HDR0(8'hA5), .HDR1(8'h5A)) dut (
    .clk(clk),
    .reset(reset),
    .write_done(write_done),
    .read_addr(read_addr),
    .dout(dout),
    .txd(txd),
    .busy(busy),
    .frame_done(frame_done),
    .overrun(overrun)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  always @(posedge clk) dout <= mem[read_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // UART decoder: samples mid-bit on falling edges and pops the scoreboard per byte.
  initial begin
    mon_act = 1'b0;
    mon_off = 0;
    mon_b   = 8'h00;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        mon_act = 1'b0;
      end else if (!mon_act) begin
        if (txd === 1'b0) begin
          mon_act = 1'b1;
          mon_off = 0;
        end
      end else begin
        mon_off++;
        if (mon_off % DIV == DIV / 2) begin
          mon_bi = mon_off / DIV;
          if (mon_bi == 0) begin
            check("start_bit", {31'd0, txd}, 32'd0);
          end else if (mon_bi <= 8) begin
            mon_b[3'(mon_bi - 1)] = txd;
          end else begin
            check("stop_bit", {31'd0, txd}, 32'd1);
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_byte: got 0x%0h expected none", mon_b);
            end else begin
              check("uart_byte", {24'd0, mon_b}, {24'd0, exp_q.pop_front()});
            end
            mon_act = 1'b0;
          end
        end
      end
    end
  end

  task automatic push_frame();
    logic [7:0] s;
    s = 8'd0;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back(mem[i]);
      s = s + mem[i];
    end
`ifdef BUFF_TX_CKSUM_EN
    exp_q.push_back(s);
`endif
  endtask

  // Called #1 after a rising edge; pulses write_done for exactly one edge.
  task automatic start_frame(input string tag);
    push_frame();
    write_done = 1'b1;
    @(posedge clk);
    #1;
    write_done = 1'b0;
    start_cyc = cyc;
    check({tag, "_busy_up"}, {31'd0, busy}, 32'd1);
    check({tag, "_txd_start"}, {31'd0, txd}, 32'd0);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (frame_done !== 1'b1 && n < FRAME_CYC + 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_frame_len"}, 32'(cyc - start_cyc), 32'(FRAME_CYC));
    check({tag, "_busy_drop"}, {31'd0, busy}, 32'd0);
    check({tag, "_addr_zero"}, {24'd0, read_addr}, 32'd0);
    check({tag, "_all_bytes"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int viol;
    reset      = 1'b1;
    write_done = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_addr", {24'd0, read_addr}, 32'd0);
    reset = 1'b0;

    viol = 0;
    repeat (1000) begin
      @(posedge clk);
      #1;
      if (txd !== 1'b1 || busy !== 1'b0 || read_addr !== 8'd0 || overrun !== 1'b0) viol++;
    end
    check("idle_violations", 32'(viol), 32'd0);

    start_frame("ramp");
    wait_done("ramp");
    check("ramp_overrun", {31'd0, overrun}, 32'd0);

    start_frame("b2b_a");
    wait_done("b2b_a");
    start_frame("b2b_b");
    check("b2b_overrun", {31'd0, overrun}, 32'd0);
    wait_done("b2b_b");
    check("b2b_overrun_end", {31'd0, overrun}, 32'd0);

    start_frame("ovr");
    repeat (102 * BYTE_CYC + 10) @(posedge clk);
    #1;
    write_done = 1'b1;
    @(posedge clk);
    #1;
    write_done = 1'b0;
    check("ovr_set", {31'd0, overrun}, 32'd1);
    check("ovr_busy", {31'd0, busy}, 32'd1);
    wait_done("ovr");
    repeat (20) @(posedge clk);
    #1;
    check("ovr_sticky", {31'd0, overrun}, 32'd1);

    start_frame("abort");
    repeat (52 * BYTE_CYC + 13) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    exp_q.delete();
    check("abort_txd", {31'd0, txd}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_addr", {24'd0, read_addr}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_overrun_clr", {31'd0, overrun}, 32'd0);

    for (int i = 0; i < 256; i++) mem[i] = 8'hFF ^ 8'(i);
    @(posedge clk);
    #1;
    start_frame("inv");
    wait_done("inv");

    repeat (20) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
